// File: rtl/maroc_hit_list.sv
// Hit-mask expander: streams set-bit indices of a captured 256-bit mask, lowest first.
// Optional trailer word carrying the hit count is enabled with `define HIT_LIST_TRL_EN.
module maroc_hit_list (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] hit_mask,
    input  logic         hit_vld,
    output logic         cap_rdy,
    output logic [8:0]   idx_data,
    output logic         idx_vld,
    input  logic         idx_rdy,
    output logic         idx_last,
    output logic         idx_trl,
    output logic         done
);

`ifdef HIT_LIST_TRL_EN
    typedef enum logic [1:0] {IDLE, SCAN, TRL} state_t;
`else
    typedef enum logic {IDLE, SCAN} state_t;
`endif

    state_t       state_q, state_d;
    logic [255:0] work_q, work_d;
    logic [8:0]   data_d;
    logic         vld_d, last_d, done_d, cap_d;
    logic         xfer, scan_end, work_d_nz, work_d_one;
`ifdef HIT_LIST_TRL_EN
    logic [8:0]   cnt_q, cnt_d;
`endif

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [7:0] lsb_idx(input logic [255:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 255; i >= 0; i--)
            if (v[i]) r = 8'(i);
        return r;
    endfunction

    assign xfer = idx_vld && idx_rdy;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d  = state_q;
        work_d   = work_q;
        done_d   = 1'b0;
        scan_end = 1'b0;
`ifdef HIT_LIST_TRL_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (hit_vld) begin
                    work_d  = hit_mask;
                    state_d = SCAN;
`ifdef HIT_LIST_TRL_EN
                    cnt_d   = '0;
`endif
                end
            end
            SCAN: begin
                if (work_q == '0) begin
                    scan_end = 1'b1;
                end else if (xfer) begin
                    work_d = work_q & (work_q - 256'd1);
`ifdef HIT_LIST_TRL_EN
                    cnt_d  = cnt_q + 9'd1;
`endif
                    if (work_d == '0) scan_end = 1'b1;
                end
            end
`ifdef HIT_LIST_TRL_EN
            TRL: begin
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (scan_end) begin
`ifdef HIT_LIST_TRL_EN
            state_d = TRL;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
        end

        // Outputs are registered, so they are derived from the next-cycle state.
        work_d_nz  = (work_d != '0);
        work_d_one = work_d_nz && ((work_d & (work_d - 256'd1)) == '0);
        cap_d      = (state_d == IDLE);
        vld_d      = (state_d == SCAN) && work_d_nz;
        data_d     = {1'b0, lsb_idx(work_d)};
`ifdef HIT_LIST_TRL_EN
        last_d     = 1'b0;
        if (state_d == TRL) begin
            vld_d  = 1'b1;
            last_d = 1'b1;
            data_d = cnt_d;
        end
`else
        last_d     = (state_d == SCAN) && work_d_one;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed above.
    // NOTE: the 256-bit work register is reset along with the control so an aborted
    // frame leaves no stale hits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cap_rdy  <= 1'b1;
            idx_vld  <= 1'b0;
            idx_data <= '0;
            idx_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cap_rdy  <= cap_d;
            idx_vld  <= vld_d;
            idx_data <= data_d;
            idx_last <= last_d;
            done     <= done_d;
        end
    end

`ifdef HIT_LIST_TRL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_trl <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_trl <= (state_d == TRL);
        end
    end
`else
    assign idx_trl = 1'b0;
`endif

endmodule
